tick_gen: RTL and testbench

Parametrised multi-channel timebase: each of NUM_CH channels divides `clk` by a runtime-programmable period and produces a one-cycle `tick` strobe plus a 50%-duty `toggle` square wave. It replaces the fixed single-output half-second divider and sits beside the top level, feeding tile-animation steps, keypad sampling and display refresh from one block. Channels support enable/pause, synchronous restart and, optionally, one-shot operation.

---
 rtl/tick_gen_pkg.sv | 21 ++
 rtl/tick_gen_ch.sv | 96 +++++++++
 rtl/tick_gen.sv | 53 +++++
 tb/tb_tick_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants, per-channel action encoding and period helper for tick_gen.
package tick_gen_pkg;

  localparam int unsigned DEF_CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_PERIOD_500MS = DEF_CLK_HZ / 4;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_COUNT,
    ACT_WRAP,
    ACT_CLEAR
  } ch_act_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    longint unsigned prod;
    prod = 64'(clk_hz) * 64'(ms) / 64'd1000;
    return 32'(prod);
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick_gen channel: counter, period register and registered tick/toggle.
// One-shot halt/done logic exists only when TICK_GEN_ONESHOT_EN is defined.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_500MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic             per_we,
  input  logic [CNT_W-1:0] per_val,
  output logic             tick,
  output logic             toggle,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per;
  logic             wrap;
  logic             halted;
  ch_act_t          act;

  // Periods 0 and 1 both mean "every enabled edge"; >= lets a shrunken period wrap at once.
  assign wrap = (per[CNT_W-1:1] == '0) || (cnt >= per - 1'b1);

`ifdef TICK_GEN_ONESHOT_EN
  logic halt;

  assign halted = halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt <= 1'b0;
      done <= 1'b0;
    end else if (act == ACT_CLEAR) begin
      halt <= 1'b0;
      done <= 1'b0;
    end else if (act == ACT_WRAP && mode) begin
      halt <= 1'b1;
      done <= 1'b1;
    end
  end
`else
  logic mode_unused;

  assign mode_unused = mode;
  assign halted      = 1'b0;
  assign done        = 1'b0;
`endif

  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLEAR;
    end else if (en && !halted) begin
      act = wrap ? ACT_WRAP : ACT_COUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      per    <= CNT_W'(DEF_PERIOD);
      tick   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      if (per_we) begin
        per <= per_val;
      end
      unique case (act)
        ACT_CLEAR: begin
          cnt    <= '0;
          tick   <= 1'b0;
          toggle <= 1'b0;
        end
        ACT_WRAP: begin
          cnt    <= '0;
          tick   <= 1'b1;
          toggle <= ~toggle;
        end
        ACT_COUNT: begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
        default: begin
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable timebase: NUM_CH independent tick/toggle dividers.
// Optional one-shot mode is built when TICK_GEN_ONESHOT_EN is defined.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = (CLK_HZ == DEF_CLK_HZ) ? DEF_PERIOD_500MS
                                                             : ms_to_cycles(CLK_HZ, 250)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            en,
  input  logic [NUM_CH-1:0]                            clr,
  input  logic [NUM_CH-1:0]                            mode,
  input  logic                                         period_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] period_ch,
  input  logic [CNT_W-1:0]                             period_val,
  output logic [NUM_CH-1:0]                            tick,
  output logic [NUM_CH-1:0]                            toggle,
  output logic [NUM_CH-1:0]                            done
);

  logic [NUM_CH-1:0] ch_we;

  // Indices at or above NUM_CH match no channel and are dropped.
  always_comb begin
    ch_we = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_we[i] = period_we && (32'(period_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .clr     (clr[g]),
      .mode    (mode[g]),
      .per_we  (ch_we[g]),
      .per_val (period_val),
      .tick    (tick[g]),
      .toggle  (toggle[g]),
      .done    (done[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus randomized traffic
// against a per-channel "enabled edges since restart" reference model.
module tb_tick_gen;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEF_P  = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned OW     = 3 * NUM_CH;
`ifdef TICK_GEN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] mode;
  logic              period_we;
  logic [CH_W-1:0]   period_ch;
  logic [CNT_W-1:0]  period_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] toggle;
  logic [NUM_CH-1:0] done;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_per     [NUM_CH];
  int unsigned m_elapsed [NUM_CH];
  bit          m_tick    [NUM_CH];
  bit          m_tog     [NUM_CH];
  bit          m_done    [NUM_CH];

  tick_gen #(
    .CLK_HZ     (1000),
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .mode       (mode),
    .period_we  (period_we),
    .period_ch  (period_ch),
    .period_val (period_val),
    .tick       (tick),
    .toggle     (toggle),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A tick falls on the edge where the enabled-edge count since restart reaches max(per,1).
  task automatic model_edge();
    int unsigned peff;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!rst_n) begin
        m_per[i] = DEF_P; m_elapsed[i] = 0;
        m_tick[i] = 0; m_tog[i] = 0; m_done[i] = 0;
        continue;
      end
      peff = (m_per[i] == 0) ? 1 : m_per[i];
      if (clr[i]) begin
        m_elapsed[i] = 0; m_tick[i] = 0; m_tog[i] = 0; m_done[i] = 0;
      end else if (en[i] && !m_done[i]) begin
        if (m_elapsed[i] + 1 >= peff) begin
          m_elapsed[i] = 0; m_tick[i] = 1; m_tog[i] = !m_tog[i];
          if (ONESHOT && mode[i]) m_done[i] = 1;
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1; m_tick[i] = 0;
        end
      end else begin
        m_tick[i] = 0;
      end
      if (period_we && int'(period_ch) == i) m_per[i] = 32'(period_val);
    end
  endtask

  function automatic logic [OW-1:0] model_outs();
    logic [OW-1:0] r;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      r[2*NUM_CH+i] = m_tick[i];
      r[NUM_CH+i]   = m_tog[i];
      r[i]          = m_done[i];
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int first = -1;
    int ticks = 0;
    rst_n = 0; en = '1; clr = '0; mode = '0;
    period_we = 0; period_ch = '0; period_val = '0;
    repeat (3) cycle();
    n_checks++;
    if ({tick, toggle, done} !== '0) begin
      n_errors++; $display("FAIL reset_outs: got %b expected 0", {tick, toggle, done});
    end
    rst_n = 1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL reset_run e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
      if (tick[0]) begin
        ticks++;
        if (first < 0) first = e;
      end
      if (e == 4 || e == 8 || e == 12) begin
        n_checks++;
        if (toggle[0] !== ((e == 8) ? 1'b0 : 1'b1)) begin
          n_errors++; $display("FAIL toggle_phase e=%0d: got %b", e, toggle[0]);
        end
      end
    end
    n_checks++;
    if (first != 4) begin
      n_errors++; $display("FAIL first_tick: got edge %0d expected 4", first);
    end
    n_checks++;
    if (ticks != 5) begin
      n_errors++; $display("FAIL tick_rate: got %0d ticks expected 5", ticks);
    end
  endtask

  task automatic test_period_write();
    int ticks = 0;
    en = '1;
    period_we = 1; period_ch = 2'd1; period_val = 16'd10;
    cycle();
    period_we = 0; clr = '1;
    cycle();
    clr = '0;
    repeat (7) begin
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL pw_pre: got %b expected %b", {tick, toggle, done}, model_outs());
      end
    end
    period_we = 1; period_ch = 2'd1; period_val = 16'd5;
    cycle();
    period_we = 0;
    n_checks++;
    if (tick[1] !== 1'b0) begin
      n_errors++; $display("FAIL pw_write_edge: got tick %b expected 0", tick[1]);
    end
    cycle();
    n_checks++;
    if (tick[1] !== 1'b1) begin
      n_errors++; $display("FAIL pw_wrap_now: got tick %b expected 1", tick[1]);
    end
    for (int e = 0; e < 20; e++) begin
      if (e == 10) begin
        period_we = 1; period_ch = 2'd3; period_val = 16'd2;
      end
      cycle();
      period_we = 0;
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL pw_run e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
      if (e >= 10 && tick[1]) ticks++;
    end
    n_checks++;
    if (ticks != 2) begin
      n_errors++; $display("FAIL pw_bad_index: got %0d ticks in 10 edges expected 2", ticks);
    end
  endtask

  task automatic test_pause();
    int first = -1;
    en = '1;
    period_we = 1; period_ch = 2'd2; period_val = 16'd6;
    cycle();
    period_we = 0; clr = '1;
    cycle();
    clr = '0;
    for (int e = 1; e <= 12; e++) begin
      en[2] = !(e >= 3 && e <= 5);
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL pause_run e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
      if (tick[2] && first < 0) first = e;
    end
    en = '1;
    n_checks++;
    if (first != 9) begin
      n_errors++; $display("FAIL pause_delay: got edge %0d expected 9", first);
    end
  endtask

  task automatic test_period_0_1();
    en = '1;
    period_we = 1; period_ch = 2'd0; period_val = 16'd0;
    cycle();
    period_ch = 2'd1; period_val = 16'd1;
    cycle();
    period_we = 0; clr = '1;
    cycle();
    clr = '0;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      n_checks++;
      if (tick[1:0] !== 2'b11 || toggle[0] !== e[0] || toggle[1] !== e[0]) begin
        n_errors++; $display("FAIL fast_period e=%0d: got tick %b toggle %b", e, tick[1:0], toggle[1:0]);
      end
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL fast_model e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
    end
  endtask

  task automatic test_oneshot();
    int first = -1;
    int ticks = 0;
    en = '1; mode = 3'b001;
    period_we = 1; period_ch = 2'd0; period_val = 16'd3;
    cycle();
    period_we = 0; clr = 3'b001;
    cycle();
    clr = '0;
    for (int e = 1; e <= 23; e++) begin
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL os_run e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
      if (tick[0]) begin
        ticks++;
        if (first < 0) first = e;
      end
    end
    n_checks++;
    if (first != 3 || ticks != (ONESHOT ? 1 : 7) || done[0] !== ONESHOT) begin
      n_errors++; $display("FAIL os_fire: got first %0d ticks %0d done %b", first, ticks, done[0]);
    end
    clr = 3'b001;
    cycle();
    clr = '0;
    n_checks++;
    if (done[0] !== 1'b0) begin
      n_errors++; $display("FAIL os_clear: got done %b expected 0", done[0]);
    end
    for (int e = 1; e <= 3; e++) begin
      cycle();
      n_checks++;
      if (tick[0] !== (e == 3) || {tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL os_rearm e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
    end
    mode = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en   = NUM_CH'($urandom);
      clr  = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      mode = NUM_CH'($urandom);
      period_we  = ($urandom_range(0, 7) == 0);
      period_ch  = CH_W'($urandom_range(0, 3));
      period_val = CNT_W'($urandom_range(0, 9));
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL random c=%0d: got %b expected %b", c, {tick, toggle, done}, model_outs());
      end
    end
    en = '1; clr = '0; mode = '0; period_we = 0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    period_we = 1; period_ch = 2'd0; period_val = 16'd100;
    cycle();
    period_we = 0; clr = '1;
    cycle();
    clr = '0;
    repeat (10) cycle();
    rst_n = 0; period_we = 1;
    cycle();
    period_we = 0;
    n_checks++;
    if ({tick, toggle, done} !== '0) begin
      n_errors++; $display("FAIL mid_reset: got %b expected 0", {tick, toggle, done});
    end
    rst_n = 1;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      n_checks++;
      if ({tick, toggle, done} !== model_outs()) begin
        n_errors++; $display("FAIL mid_run e=%0d: got %b expected %b", e, {tick, toggle, done}, model_outs());
      end
      if (tick[0] && first < 0) first = e;
    end
    n_checks++;
    if (first != 4) begin
      n_errors++; $display("FAIL mid_def_period: got edge %0d expected 4", first);
    end
  endtask

  initial begin
    test_reset();
    test_period_write();
    test_pause();
    test_period_0_1();
    test_oneshot();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
